// File: rtl/mem_req_arbiter_pkg.sv
// Shared encodings for the memory request arbiter: the owner tag stored per
// outstanding request and the transfer size codes used on the memory port.
package mem_req_arbiter_pkg;

  // Owner of an outstanding request; the value is what the owner FIFO stores.
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order FIFO of owner tags, one entry per accepted memory request.
// Depth must be a power of two so the pointers wrap by natural overflow.
module owner_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  owner_e        i_push_owner,
  input  logic          i_pop,
  output owner_e        o_head_owner,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  owner_e        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_empty      = (r_count == '0);
  assign w_push       = i_push && !o_full;
  assign w_pop        = i_pop && !o_empty;
  assign o_head_owner = r_mem[r_rd_ptr];
  assign o_count      = r_count;

  // Tag storage written at the tail on every push.
  // NOTE: the storage array has no reset; entries are only read once the
  // count says they were written, and leaving them unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_owner;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one sram-like
// memory port, tracks outstanding requests in an owner FIFO and routes each
// in-order response back to its issuer.
// Optional: define MEM_ARB_PERFCNT_EN to add per-requester wait-cycle counters.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERFCNT_EN
  ,
  output logic [31:0] perfcnt_inst_wait,
  output logic [31:0] perfcnt_data_wait
`endif
);

  localparam int FIFO_CW = $clog2(MAX_OUTSTANDING) + 1;

  logic               r_lock;
  owner_e             r_lock_owner;
  logic [CNT_W-1:0]   r_starve;

  owner_e             w_grant;
  owner_e             w_head_owner;
  logic [FIFO_CW-1:0] w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_starved;
  logic               w_accept;
  logic               w_pop;

  assign w_starved = (r_starve >= CNT_W'(STARVE_LIMIT));

  // Grant select: a pending stall keeps its owner, otherwise data has priority
  // unless instruction fetch has waited through too many data grants.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = OWNER_INST;
    if (r_lock) begin
      w_grant = r_lock_owner;
    end else if (data_req && !(w_starved && inst_req)) begin
      w_grant = OWNER_DATA;
    end
  end

  // Memory port fields come from the granted requester's live inputs.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = SIZE_WORD;
    mem_addr  = inst_addr;
    mem_wdata = 32'd0;
    if (w_grant == OWNER_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  // Issue only with a free FIFO slot as of the start of the cycle; a pop in
  // the same cycle does not open a slot until the next one.
  assign mem_req  = !reset && (inst_req || data_req) &&
                    (w_count < FIFO_CW'(MAX_OUTSTANDING));
  assign w_accept = mem_req && mem_addr_ok;

  assign inst_addr_ok = w_accept && (w_grant == OWNER_INST);
  assign data_addr_ok = w_accept && (w_grant == OWNER_DATA);

  // Responses pop the head owner; a response with nothing outstanding is dropped.
  assign w_pop        = !reset && mem_data_ok && !w_empty;
  assign inst_data_ok = w_pop && (w_head_owner == OWNER_INST);
  assign data_data_ok = w_pop && (w_head_owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_accept),
    .i_push_owner (w_grant),
    .i_pop        (w_pop),
    .o_head_owner (w_head_owner),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  // Lock the grant while memory stalls an issued request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock       <= 1'b0;
      r_lock_owner <= OWNER_INST;
    end else if (mem_req && !mem_addr_ok) begin
      r_lock       <= 1'b1;
      r_lock_owner <= w_grant;
    end else if (w_accept) begin
      r_lock       <= 1'b0;
    end
  end

  // Count data grants taken while instruction fetch waits, saturating.
  always_ff @(posedge clk) begin
    if (reset || !inst_req) begin
      r_starve <= '0;
    end else if (inst_addr_ok) begin
      r_starve <= '0;
    end else if (data_addr_ok && !w_starved) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end

`ifdef MEM_ARB_PERFCNT_EN
  logic [31:0] r_perf_inst;
  logic [31:0] r_perf_data;

  // Wait-cycle counters: requesting but not accepted this cycle; wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_inst <= 32'd0;
      r_perf_data <= 32'd0;
    end else begin
      if (inst_req && !inst_addr_ok) r_perf_inst <= r_perf_inst + 32'd1;
      if (data_req && !data_addr_ok) r_perf_data <= r_perf_data + 32'd1;
    end
  end

  assign perfcnt_inst_wait = r_perf_inst;
  assign perfcnt_data_wait = r_perf_data;
`endif

  // Interface sanity checks, simulation only in effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_data_ok && w_empty))
        else $warning("mem_data_ok with no outstanding request, ignored");
      assert (!(w_accept && w_full))
        else $error("owner FIFO overflow");
      assert (!data_req || (data_size inside {SIZE_BYTE, SIZE_HALF, SIZE_WORD}))
        else $error("illegal data_size %0d", data_size);
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter. Inputs change on the
// falling edge; combinational outputs are sampled 1 ns later.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERFCNT_EN
  logic [31:0] perfcnt_inst_wait;
  logic [31:0] perfcnt_data_wait;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT   (8),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
`ifdef MEM_ARB_PERFCNT_EN
    ,
    .perfcnt_inst_wait (perfcnt_inst_wait),
    .perfcnt_data_wait (perfcnt_data_wait)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = 32'd0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'd0;
    data_wdata  = 32'd0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"},      mem_req,      0);
    check({tag, "_inst_addr_ok"}, inst_addr_ok, 0);
    check({tag, "_data_addr_ok"}, data_addr_ok, 0);
    check({tag, "_inst_data_ok"}, inst_data_ok, 0);
    check({tag, "_data_data_ok"}, data_data_ok, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // ---- Reset state ----
    @(negedge clk);
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    check_quiet("rst_during");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    #1;
    check_quiet("rst_after");
`ifdef MEM_ARB_PERFCNT_EN
    check("rst_perf_inst", perfcnt_inst_wait, 0);
    check("rst_perf_data", perfcnt_data_wait, 0);
`endif

    // ---- 1: four inst reads, responses two cycles after each issue ----
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      inst_req    = (c < 4);
      inst_addr   = 32'h100 + 32'(4 * c);
      mem_addr_ok = 1'b1;
      mem_data_ok = (c >= 2);
      mem_rdata   = 32'hA0 + 32'(c) - 32'd2;
      #1;
      check("t1_inst_addr_ok", inst_addr_ok, (c < 4));
      if (c < 4) check("t1_mem_addr", mem_addr, 32'h100 + 32'(4 * c));
      if (c == 0) begin
        check("t1_mem_wr", mem_wr, 0);
        check("t1_mem_size", mem_size, 2);
        check("t1_mem_wdata", mem_wdata, 0);
      end
      check("t1_inst_data_ok", inst_data_ok, (c >= 2));
      if (c >= 2) check("t1_inst_rdata", inst_rdata, 32'hA0 + 32'(c) - 32'd2);
      check("t1_data_data_ok", data_data_ok, 0);
    end
    @(negedge clk);
    idle_inputs();

    // ---- 2: both requesting, memory always ready: 8 data then 1 inst ----
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      inst_req    = 1'b1;
      inst_addr   = 32'h500;
      data_req    = 1'b1;
      data_addr   = 32'h4000 + 32'(c);
      mem_addr_ok = 1'b1;
      mem_data_ok = (c >= 1);
      mem_rdata   = 32'(c);
      #1;
      check("t2_inst_addr_ok", inst_addr_ok, (c == 8 || c == 17));
      check("t2_data_addr_ok", data_addr_ok, !(c == 8 || c == 17));
      check("t2_inst_data_ok", inst_data_ok, (c == 9));
      check("t2_data_data_ok", data_data_ok, (c >= 1 && c != 9));
    end
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1'b1;
    #1;
    check("t2_last_inst_data_ok", inst_data_ok, 1);
    check("t2_last_data_data_ok", data_data_ok, 0);
    check("t2_last_mem_req", mem_req, 0);
    @(negedge clk);
    idle_inputs();

    // ---- 3: data stalled 3 cycles, inst arrives during the stall ----
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_req    = 1'b1;
      data_wr     = 1'b1;
      data_size   = 2'd1;
      data_addr   = 32'h2000;
      data_wdata  = 32'hDEAD;
      inst_req    = (c >= 1);
      inst_addr   = 32'h300;
      mem_addr_ok = (c == 3);
      #1;
      check("t3_mem_req", mem_req, 1);
      check("t3_mem_addr", mem_addr, 32'h2000);
      check("t3_mem_wr", mem_wr, 1);
      check("t3_mem_size", mem_size, 1);
      check("t3_mem_wdata", mem_wdata, 32'hDEAD);
      check("t3_data_addr_ok", data_addr_ok, (c == 3));
      check("t3_inst_addr_ok", inst_addr_ok, 0);
    end
    @(negedge clk);
    data_req = 1'b0;
    mem_addr_ok = 1'b1;
    #1;
    check("t3_inst_after_addr_ok", inst_addr_ok, 1);
    check("t3_inst_after_mem_addr", mem_addr, 32'h300);
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1'b1;
    #1;
    check("t3_resp0_data", data_data_ok, 1);
    check("t3_resp0_inst", inst_data_ok, 0);
    @(negedge clk);
    mem_data_ok = 1'b1;
    #1;
    check("t3_resp1_inst", inst_data_ok, 1);
    check("t3_resp1_data", data_data_ok, 0);
    @(negedge clk);
    idle_inputs();

    // ---- 4: FIFO full blocks issue; a pop reopens it one cycle later ----
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_req    = 1'b1;
      data_addr   = 32'h6000 + 32'(4 * c);
      mem_addr_ok = 1'b1;
      #1;
      check("t4_fill_addr_ok", data_addr_ok, 1);
    end
    @(negedge clk);
    inst_req = 1'b1;
    #1;
    check("t4_full_mem_req", mem_req, 0);
    check("t4_full_data_addr_ok", data_addr_ok, 0);
    check("t4_full_inst_addr_ok", inst_addr_ok, 0);
    @(negedge clk);
    mem_data_ok = 1'b1;
    #1;
    check("t4_pop_data_data_ok", data_data_ok, 1);
    check("t4_pop_same_cycle_mem_req", mem_req, 0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    check("t4_reopen_mem_req", mem_req, 1);
    check("t4_reopen_data_addr_ok", data_addr_ok, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      mem_data_ok = 1'b1;
      #1;
      check("t4_drain_data_data_ok", data_data_ok, 1);
    end
    @(negedge clk);
    idle_inputs();

    // ---- 5: interleaved inst/data/inst, routing by owner ----
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h700; mem_addr_ok = 1'b1;
    #1;
    check("t5_issue0_inst", inst_addr_ok, 1);
    @(negedge clk);
    inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000;
    #1;
    check("t5_issue1_data", data_addr_ok, 1);
    @(negedge clk);
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h704;
    #1;
    check("t5_issue2_inst", inst_addr_ok, 1);
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h11;
    #1;
    check("t5_r0_inst_ok", inst_data_ok, 1);
    check("t5_r0_data_ok", data_data_ok, 0);
    check("t5_r0_inst_rdata", inst_rdata, 32'h11);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h22;
    #1;
    check("t5_r1_data_ok", data_data_ok, 1);
    check("t5_r1_inst_ok", inst_data_ok, 0);
    check("t5_r1_data_rdata", data_rdata, 32'h22);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h33;
    #1;
    check("t5_r2_inst_ok", inst_data_ok, 1);
    check("t5_r2_data_ok", data_data_ok, 0);
    check("t5_r2_inst_rdata", inst_rdata, 32'h33);
    @(negedge clk);
    mem_data_ok = 1'b1; mem_rdata = 32'h44;
    #1;
    check("t5_spurious_inst_ok", inst_data_ok, 0);
    check("t5_spurious_data_ok", data_data_ok, 0);
    @(negedge clk);
    idle_inputs();

    // ---- 6: reset with 3 outstanding drops them ----
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h900 + 32'(4 * c); mem_addr_ok = 1'b1;
      #1;
      check("t6_fill_inst_addr_ok", inst_addr_ok, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_quiet("t6_in_reset");
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h55;
    #1;
    check_quiet("t6_after_reset");
`ifdef MEM_ARB_PERFCNT_EN
    check("t6_perf_inst", perfcnt_inst_wait, 0);
    check("t6_perf_data", perfcnt_data_wait, 0);
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      data_req = 1'b1; data_addr = 32'hA000 + 32'(4 * c); mem_addr_ok = 1'b1;
      #1;
      check("t6_refill_data_addr_ok", data_addr_ok, 1);
    end
    @(negedge clk);
    #1;
    check("t6_full_mem_req", mem_req, 0);
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1'b1;
    #1;
    check("t6_drain_data_data_ok", data_data_ok, 1);
`ifdef MEM_ARB_PERFCNT_EN
    check("t6_perf_data_one", perfcnt_data_wait, 1);
    check("t6_perf_inst_zero", perfcnt_inst_wait, 0);
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_data_ok = 1'b1;
      #1;
      check("t6_drain_rest", data_data_ok, 1);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
